// File: rtl/checkpoint_ctrl.sv
// checkpoint_ctrl: branch checkpoint slot manager.
// Tracks up to NUM_CKPT in-flight branch snapshots: allocation of the lowest
// free slot, release on correct resolution, and squash of a mispredicted
// branch together with every younger checkpoint (via an age matrix).
// Optional macro CKPT_STATS_EN adds 16-bit saturating stall/flush counters;
// without it stall_cnt and flush_cnt are tied to zero.
module checkpoint_ctrl #(
    parameter int NUM_CKPT = 8,
    parameter int TAG_W    = 5,
    localparam int ID_W    = $clog2(NUM_CKPT),
    localparam int CNT_W   = ID_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_req,
    input  logic [TAG_W-1:0] alloc_rob_tag,
    output logic             alloc_ready,
    output logic [ID_W-1:0]  alloc_id,
    input  logic             hit,
    input  logic [TAG_W-1:0] hit_tag,
    input  logic             mispredict,
    input  logic [TAG_W-1:0] mispredict_tag,
    output logic             restore_valid,
    output logic [ID_W-1:0]  restore_id,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic [15:0]      stall_cnt,
    output logic [15:0]      flush_cnt
);

    // Slot state: valid bits, stored ROB tags, and the age matrix where
    // older_reg[i][j] = 1 means slot i was allocated before slot j.
    logic [NUM_CKPT-1:0] valid_reg;
    logic [NUM_CKPT-1:0] valid_next;
    logic [TAG_W-1:0]    tag_reg   [NUM_CKPT];
    logic [NUM_CKPT-1:0] older_reg [NUM_CKPT];
    logic [CNT_W-1:0]    count_reg;
    logic [CNT_W-1:0]    count_next;

    logic [NUM_CKPT-1:0] hit_match;
    logic [NUM_CKPT-1:0] mis_match;
    logic                hit_any;
    logic                mis_any;
    logic [ID_W-1:0]     hit_id;
    logic [ID_W-1:0]     mis_id;
    logic [ID_W-1:0]     free_id;
    logic [NUM_CKPT-1:0] kill_mask;
    logic                alloc_fire;

    // Per-slot tag comparators against the resolving branch tags.
    for (genvar gi = 0; gi < NUM_CKPT; gi++) begin : g_match
        assign hit_match[gi] = valid_reg[gi] && (tag_reg[gi] == hit_tag);
        assign mis_match[gi] = valid_reg[gi] && (tag_reg[gi] == mispredict_tag);
    end

    assign hit_any = |hit_match;
    assign mis_any = |mis_match;

    // Lowest-index priority encoders: matches (duplicate tags resolve to the
    // lowest slot) and the first free slot (0 when every slot is in use).
    always_comb begin
        hit_id  = '0;
        mis_id  = '0;
        free_id = '0;
        for (int i = NUM_CKPT - 1; i >= 0; i--) begin
            if (hit_match[i]) hit_id  = ID_W'(i);
            if (mis_match[i]) mis_id  = ID_W'(i);
            if (!valid_reg[i]) free_id = ID_W'(i);
        end
    end

    assign full          = (count_reg == CNT_W'(NUM_CKPT));
    assign empty         = (count_reg == '0);
    assign count         = count_reg;
    assign alloc_id      = free_id;
    assign alloc_ready   = !full && !mispredict;
    assign alloc_fire    = alloc_req && alloc_ready;
    // Restore is suppressed while reset is asserted so a squash racing a
    // reset never produces a spurious restore pulse.
    assign restore_valid = mispredict && mis_any && !reset;
    assign restore_id    = mis_id;

    // The mispredicted slot plus everything allocated after it.
    assign kill_mask = older_reg[mis_id] | (NUM_CKPT'(1) << mis_id);

    // Next valid vector: a squash takes priority and drops alloc/hit;
    // otherwise hit-release and allocation both apply (they never touch the
    // same slot because alloc only targets an already-free slot).
    always_comb begin
        valid_next = valid_reg;
        if (mispredict) begin
            if (mis_any) valid_next = valid_reg & ~kill_mask;
        end else begin
            if (hit && hit_any) valid_next[hit_id]   = 1'b0;
            if (alloc_fire)     valid_next[free_id]  = 1'b1;
        end
    end

    // Population count of the next valid vector so count stays registered.
    always_comb begin
        count_next = '0;
        for (int i = 0; i < NUM_CKPT; i++) begin
            count_next = count_next + CNT_W'(valid_next[i]);
        end
    end

    // Valid bits and occupancy register.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg <= '0;
            count_reg <= '0;
        end else begin
            valid_reg <= valid_next;
            count_reg <= count_next;
        end
    end

    // Tag capture and age-matrix update on allocation: the new slot is
    // younger than every currently valid slot and older than none.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                tag_reg[i]   <= '0;
                older_reg[i] <= '0;
            end
        end else if (alloc_fire) begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                if (free_id == ID_W'(i)) begin
                    tag_reg[i]   <= alloc_rob_tag;
                    older_reg[i] <= '0;
                end else begin
                    older_reg[i][free_id] <= valid_reg[i];
                end
            end
        end
    end

`ifdef CKPT_STATS_EN
    logic [15:0] stall_cnt_reg;
    logic [15:0] flush_cnt_reg;

    // Saturating counters: stalled allocation attempts and effective squashes.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (alloc_req && full && (stall_cnt_reg != 16'hFFFF))
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            if (mispredict && mis_any && (flush_cnt_reg != 16'hFFFF))
                flush_cnt_reg <= flush_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`else
    assign stall_cnt = 16'd0;
    assign flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_checkpoint_ctrl.sv
// Bench for checkpoint_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared each cycle against a slot/sequence model.
module tb_checkpoint_ctrl;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        alloc_req;
    logic [4:0]  alloc_rob_tag;
    logic        alloc_ready;
    logic [2:0]  alloc_id;
    logic        hit;
    logic [4:0]  hit_tag;
    logic        mispredict;
    logic [4:0]  mispredict_tag;
    logic        restore_valid;
    logic [2:0]  restore_id;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    checkpoint_ctrl #(.NUM_CKPT(N), .TAG_W(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .alloc_req      (alloc_req),
        .alloc_rob_tag  (alloc_rob_tag),
        .alloc_ready    (alloc_ready),
        .alloc_id       (alloc_id),
        .hit            (hit),
        .hit_tag        (hit_tag),
        .mispredict     (mispredict),
        .mispredict_tag (mispredict_tag),
        .restore_valid  (restore_valid),
        .restore_id     (restore_id),
        .count          (count),
        .full           (full),
        .empty          (empty),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    // Model: each slot holds valid, tag and an allocation sequence number;
    // "younger" simply means a larger sequence number.
    bit         m_valid [N];
    logic [4:0] m_tag   [N];
    int         m_seq   [N];
    int         m_next_seq = 0;
    int         m_stall = 0;
    int         m_flush = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_find(input logic [4:0] t);
        for (int i = 0; i < N; i++) if (m_valid[i] && m_tag[i] == t) return i;
        return -1;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_valid[i]) c++;
        return c;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
        return 0;
    endfunction

    // Compare outputs mid-cycle, then advance the model by the inputs that
    // the DUT will consume on the coming rising edge.
    always @(negedge clk) begin : cmp_proc
        int c;
        int k;
        int h;
        int a;
        c = m_count();
        k = m_find(mispredict_tag);
        if (cmp_en) begin
            chk("count", count, c);
            chk("full", full, c == N);
            chk("empty", empty, c == 0);
            chk("alloc_ready", alloc_ready, (c < N) && !mispredict);
            chk("alloc_id", alloc_id, m_free());
            chk("restore_valid", restore_valid, !reset && mispredict && (k >= 0));
            if (!reset && mispredict && (k >= 0)) chk("restore_id", restore_id, k);
            chk("stall_cnt", stall_cnt, m_stall);
            chk("flush_cnt", flush_cnt, m_flush);
        end
        if (reset) begin
            for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
            m_stall = 0;
            m_flush = 0;
        end else begin
`ifdef CKPT_STATS_EN
            if (alloc_req && c == N && m_stall < 65535) m_stall++;
            if (mispredict && k >= 0 && m_flush < 65535) m_flush++;
`endif
            if (mispredict) begin
                if (k >= 0) begin
                    int s;
                    s = m_seq[k];
                    for (int j = 0; j < N; j++) if (m_valid[j] && m_seq[j] >= s) m_valid[j] = 1'b0;
                end
            end else begin
                a = m_free();
                h = hit ? m_find(hit_tag) : -1;
                if (alloc_req && c < N) begin
                    m_valid[a] = 1'b1;
                    m_tag[a]   = alloc_rob_tag;
                    m_seq[a]   = m_next_seq;
                    m_next_seq++;
                end
                if (h >= 0) m_valid[h] = 1'b0;
            end
        end
    end

    task automatic set_in(input logic ar, input logic [4:0] at, input logic h,
                          input logic [4:0] ht, input logic m, input logic [4:0] mt);
        alloc_req      = ar;
        alloc_rob_tag  = at;
        hit            = h;
        hit_tag        = ht;
        mispredict     = m;
        mispredict_tag = mt;
    endtask

    task automatic idle();
        set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
    endtask

    task automatic alloc(input logic [4:0] t);
        set_in(1'b1, t, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        tick();
    endtask

    function automatic logic [4:0] pick_new_tag();
        logic [4:0] t;
        t = 5'($urandom_range(0, 31));
        for (int tries = 0; tries < 200 && m_find(t) >= 0; tries++) t = 5'($urandom_range(0, 31));
        return t;
    endfunction

    function automatic logic [4:0] pick_tag();
        int i;
        if (m_count() > 0 && $urandom_range(0, 99) < 80) begin
            i = $urandom_range(0, N - 1);
            while (!m_valid[i]) i = (i + 1) % N;
            return m_tag[i];
        end
        return 5'($urandom_range(0, 31));
    endfunction

    logic [15:0] exp_stall1;
    logic [15:0] exp_flush1;

    initial begin
`ifdef CKPT_STATS_EN
        exp_stall1 = 16'd1;
        exp_flush1 = 16'd1;
`else
        exp_stall1 = 16'd0;
        exp_flush1 = 16'd0;
`endif
        reset = 1'b1;
        idle();
        tick();
        cmp_en = 1'b1;
        tick();
        reset = 1'b0;

        // Post-reset state
        @(negedge clk);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_alloc_id", alloc_id, 0);
        chk("rst_restore_valid", restore_valid, 0);
        tick();

        // Three consecutive allocations land in slots 0,1,2
        set_in(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0); @(negedge clk); chk("a3_id", alloc_id, 0); tick();
        set_in(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0); @(negedge clk); chk("a7_id", alloc_id, 1); tick();
        set_in(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0); @(negedge clk); chk("a9_id", alloc_id, 2); tick();
        idle(); @(negedge clk); chk("a3_count", count, 3); chk("a3_empty", empty, 0); tick();

        // Fill, stall while full, then release slot 2 by hit
        for (int t = 10; t < 15; t++) alloc(5'(t));
        set_in(1'b1, 5'd20, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk); chk("full_flag", full, 1); chk("full_ready", alloc_ready, 0); tick();
        idle(); @(negedge clk); chk("full_count", count, 8); chk("full_stall", stall_cnt, exp_stall1); tick();
        set_in(1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0); @(negedge clk); tick();
        idle(); @(negedge clk); chk("hit_free_id", alloc_id, 2); chk("hit_count", count, 7); tick();

        // Mispredict on tag 2 squashes slots 1..3
        do_reset();
        for (int t = 1; t <= 4; t++) alloc(5'(t));
        set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd2);
        @(negedge clk); chk("mp2_rv", restore_valid, 1); chk("mp2_rid", restore_id, 1); tick();
        idle(); @(negedge clk); chk("mp2_count", count, 1); chk("mp2_free", alloc_id, 1);
        chk("mp2_flush", flush_cnt, exp_flush1); tick();

        // Reused slot 1 is younger than slot 2 and dies with it
        do_reset();
        alloc(5'd1); alloc(5'd2); alloc(5'd3);
        set_in(1'b0, 5'd0, 1'b1, 5'd2, 1'b0, 5'd0); @(negedge clk); tick();
        set_in(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0); @(negedge clk); chk("reuse_id", alloc_id, 1); tick();
        set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3); @(negedge clk); chk("mp3_rid", restore_id, 2); tick();
        idle(); @(negedge clk); chk("mp3_count", count, 1); chk("mp3_free", alloc_id, 1); tick();

        // Same-cycle hit and alloc; unknown-tag mispredict does nothing
        do_reset();
        for (int t = 1; t <= 7; t++) alloc(5'(t));
        set_in(1'b1, 5'd16, 1'b1, 5'd1, 1'b0, 5'd0); @(negedge clk); chk("ha_id", alloc_id, 7); tick();
        idle(); @(negedge clk); chk("ha_count", count, 7); chk("ha_free", alloc_id, 0); tick();
        set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd31); @(negedge clk); chk("mp31_rv", restore_valid, 0); tick();
        idle(); @(negedge clk); chk("mp31_count", count, 7); tick();

        // Mispredict on the oldest slot empties everything
        do_reset();
        for (int t = 1; t <= 4; t++) alloc(5'(t));
        set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd1); @(negedge clk); tick();
        idle(); @(negedge clk); chk("old_empty", empty, 1); chk("old_count", count, 0); tick();

        // Reset with pending mispredict: no restore, all cleared
        do_reset();
        for (int t = 1; t <= 5; t++) alloc(5'(t));
        reset = 1'b1;
        set_in(1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 5'd1); @(negedge clk); chk("rmp_rv0", restore_valid, 0); tick();
        @(negedge clk); chk("rmp_rv1", restore_valid, 0); tick();
        reset = 1'b0;
        idle(); @(negedge clk);
        chk("rmp_count", count, 0); chk("rmp_stall", stall_cnt, 0); chk("rmp_flush", flush_cnt, 0); tick();

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 4000; cyc++) begin
            reset = ($urandom_range(0, 199) == 0);
            set_in($urandom_range(0, 99) < 60, pick_new_tag(),
                   $urandom_range(0, 99) < 35, pick_tag(),
                   $urandom_range(0, 99) < 8,  pick_tag());
            tick();
        end
        reset = 1'b0;
        idle();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
